// File: rtl/dram_access_arbiter_pkg.sv
// Shared encodings and arbitration helpers for the DRAM access arbiter.
// Owner codes double as the Owner output encoding.
package dram_access_arbiter_pkg;

   localparam int unsigned OWNER_WIDTH = 2;
   localparam int unsigned STATE_WIDTH = 3;
   localparam int unsigned CPU_ADDR_WIDTH = 32;

   localparam logic [CPU_ADDR_WIDTH-1:0] DRAM_WINDOW_BASE = 32'h0800_0000;
   localparam logic [CPU_ADDR_WIDTH-1:0] DRAM_WINDOW_LAST = 32'h0BFF_FFFF;

   typedef enum logic [OWNER_WIDTH-1:0] {
      OWNER_NONE    = 2'b00,
      OWNER_CPU     = 2'b01,
      OWNER_DMA     = 2'b10,
      OWNER_REFRESH = 2'b11
   } owner_t;

   typedef enum logic [STATE_WIDTH-1:0] {
      ST_IDLE    = 3'd0,
      ST_START   = 3'd1,
      ST_WAIT    = 3'd2,
      ST_ACK     = 3'd3,
      ST_RELEASE = 3'd4
   } arbState_t;

   function automatic logic inDramWindow(input logic [CPU_ADDR_WIDTH-1:0] addr);
      return (addr >= DRAM_WINDOW_BASE) && (addr <= DRAM_WINDOW_LAST);
   endfunction

   // Refresh first, then round-robin between CPU and DMA on a tie.
   function automatic owner_t pickOwner(input logic   refreshReq,
                                        input logic   cpuReq,
                                        input logic   dmaReq,
                                        input owner_t lastServed);
      owner_t winner;
      winner = OWNER_NONE;
      if (refreshReq) begin
         winner = OWNER_REFRESH;
      end else if (cpuReq && dmaReq) begin
         winner = (lastServed == OWNER_CPU) ? OWNER_DMA : OWNER_CPU;
      end else if (cpuReq) begin
         winner = OWNER_CPU;
      end else if (dmaReq) begin
         winner = OWNER_DMA;
      end
      return winner;
   endfunction

endpackage

// File: rtl/dram_access_arbiter_access_watchdog.sv
// Saturating watchdog for the WAIT phase of a DRAM access.
// expired_c flags the cycle whose closing edge brings the count to TIMEOUT_CYCLES.
module dram_access_arbiter_access_watchdog #(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_WIDTH  = 8
) (
   input  logic Clock,
   input  logic Reset_H,
   input  logic clear,
   input  logic enable,
   output logic expired_c
);

   localparam logic [TIMEOUT_WIDTH-1:0] LIMIT      = TIMEOUT_WIDTH'(TIMEOUT_CYCLES);
   localparam logic [TIMEOUT_WIDTH-1:0] LIMIT_LESS = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

   logic [TIMEOUT_WIDTH-1:0] count;

   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable && (count != LIMIT)) begin
         count <= count + TIMEOUT_WIDTH'(1);
      end
   end

   assign expired_c = enable && (count >= LIMIT_LESS);

endmodule

// File: rtl/dram_access_arbiter.sv
// Arbitrates the DRAM controller port between CPU, DMA and refresh, sequencing
// each access grant -> start -> wait -> ack -> release with a watchdog abort.
module dram_access_arbiter
   import dram_access_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned TIMEOUT_WIDTH  = 8
) (
   input  logic                  Clock,
   input  logic                  Reset_H,
   input  logic                  CpuReq_H,
   input  logic                  CpuDramSelect_H,
   input  logic [ADDR_WIDTH-1:0] CpuAddress,
   output logic                  CpuDtack_L,
   input  logic                  DmaReq_H,
   input  logic [ADDR_WIDTH-1:0] DmaAddress,
   output logic                  DmaAck_H,
   input  logic                  RefreshReq_H,
   output logic                  RefreshGrant_H,
   output logic                  DramStart_H,
   output logic                  DramRefresh_H,
   output logic [ADDR_WIDTH-1:0] DramAddress,
   input  logic                  DramDone_H,
   output logic                  BusError_L,
   output logic [1:0]            Owner
);

   arbState_t stateQ, stateNext;
   owner_t    ownerQ, ownerNext;
   owner_t    lastServedQ, lastServedNext;
   owner_t    winner_c;

   logic [ADDR_WIDTH-1:0] addrQ, addrNext;
   logic dramStartQ, dramStartNext;
   logic dramRefreshQ, dramRefreshNext;
   logic refreshGrantQ, refreshGrantNext;
   logic dmaAckQ, dmaAckNext;
   logic cpuDtackQ, cpuDtackNext;
   logic busErrorQ, busErrorNext;

   logic cpuReqEff_c;
   logic ownerReq_c;
   logic timeout_c;

   assign cpuReqEff_c = CpuReq_H & CpuDramSelect_H;
   assign winner_c    = pickOwner(RefreshReq_H, cpuReqEff_c, DmaReq_H, lastServedQ);

   // Release waits on the raw request line of whoever owns the port.
   always_comb begin
      ownerReq_c = 1'b0;
      case (ownerQ)
         OWNER_CPU:     ownerReq_c = CpuReq_H;
         OWNER_DMA:     ownerReq_c = DmaReq_H;
         OWNER_REFRESH: ownerReq_c = RefreshReq_H;
         default:       ownerReq_c = 1'b0;
      endcase
   end

   dram_access_arbiter_access_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
   ) u_watchdog (
      .Clock     (Clock),
      .Reset_H   (Reset_H),
      .clear     (stateQ == ST_START),
      .enable    (stateQ == ST_WAIT),
      .expired_c (timeout_c)
   );

   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         stateQ <= ST_IDLE;
      end else begin
         stateQ <= stateNext;
      end
   end

   always_comb begin
      stateNext = stateQ;
      case (stateQ)
         ST_IDLE: begin
            if (winner_c != OWNER_NONE) begin
               stateNext = ST_START;
            end
         end
         ST_START: stateNext = ST_WAIT;
         ST_WAIT: begin
            if (DramDone_H) begin
               stateNext = ST_ACK;
            end else if (timeout_c) begin
               stateNext = ST_RELEASE;
            end
         end
         ST_ACK: stateNext = ST_RELEASE;
         ST_RELEASE: begin
            if (!ownerReq_c) begin
               stateNext = ST_IDLE;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   // Next values for every registered output, keyed on the state transition.
   always_comb begin
      ownerNext        = ownerQ;
      lastServedNext   = lastServedQ;
      addrNext         = addrQ;
      cpuDtackNext     = cpuDtackQ;
      busErrorNext     = busErrorQ;
      dmaAckNext       = 1'b0;
      dramStartNext    = 1'b0;
      dramRefreshNext  = 1'b0;
      refreshGrantNext = 1'b0;
      case (stateQ)
         ST_IDLE: begin
            if (stateNext == ST_START) begin
               ownerNext = winner_c;
               case (winner_c)
                  OWNER_CPU: begin
                     addrNext       = CpuAddress;
                     lastServedNext = OWNER_CPU;
                  end
                  OWNER_DMA: begin
                     addrNext       = DmaAddress;
                     lastServedNext = OWNER_DMA;
                  end
                  default: addrNext = '0;
               endcase
            end
         end
         ST_WAIT: begin
            if (stateNext == ST_ACK) begin
               cpuDtackNext = (ownerQ != OWNER_CPU);
               dmaAckNext   = (ownerQ == OWNER_DMA);
            end else if (stateNext == ST_RELEASE) begin
               busErrorNext = !((ownerQ == OWNER_CPU) || (ownerQ == OWNER_DMA));
            end
         end
         ST_RELEASE: begin
            if (stateNext == ST_IDLE) begin
               ownerNext    = OWNER_NONE;
               cpuDtackNext = 1'b1;
               busErrorNext = 1'b1;
            end
         end
         default: ;
      endcase
      dramStartNext    = (stateNext == ST_START);
      dramRefreshNext  = dramStartNext && (ownerNext == OWNER_REFRESH);
      refreshGrantNext = (ownerNext == OWNER_REFRESH);
   end

   always_ff @(posedge Clock or posedge Reset_H) begin
      if (Reset_H) begin
         ownerQ        <= OWNER_NONE;
         lastServedQ   <= OWNER_DMA;
         addrQ         <= '0;
         dramStartQ    <= 1'b0;
         dramRefreshQ  <= 1'b0;
         refreshGrantQ <= 1'b0;
         dmaAckQ       <= 1'b0;
         cpuDtackQ     <= 1'b1;
         busErrorQ     <= 1'b1;
      end else begin
         ownerQ        <= ownerNext;
         lastServedQ   <= lastServedNext;
         addrQ         <= addrNext;
         dramStartQ    <= dramStartNext;
         dramRefreshQ  <= dramRefreshNext;
         refreshGrantQ <= refreshGrantNext;
         dmaAckQ       <= dmaAckNext;
         cpuDtackQ     <= cpuDtackNext;
         busErrorQ     <= busErrorNext;
      end
   end

   assign Owner          = ownerQ;
   assign DramAddress    = addrQ;
   assign DramStart_H    = dramStartQ;
   assign DramRefresh_H  = dramRefreshQ;
   assign RefreshGrant_H = refreshGrantQ;
   assign DmaAck_H       = dmaAckQ;
   assign CpuDtack_L     = cpuDtackQ;
   assign BusError_L     = busErrorQ;

   // Start is a single-cycle pulse and the address holds for the whole access.
   assert property (@(posedge Clock) disable iff (Reset_H) dramStartQ |=> !dramStartQ);
   assert property (@(posedge Clock) disable iff (Reset_H)
      (stateQ inside {ST_WAIT, ST_ACK, ST_RELEASE}) |-> $stable(addrQ));

endmodule

// File: tb/tb_dram_access_arbiter.sv
// Randomized bench for dram_access_arbiter with a transaction-level reference:
// winner by priority/round-robin, latencies and acks from the access rules.
module tb_dram_access_arbiter;

   localparam int unsigned AW = 32;
   localparam int TO_CYCLES   = 8;
   localparam int O_NONE = 0, O_CPU = 1, O_DMA = 2, O_REF = 3;

   logic          Clock = 1'b0;
   logic          Reset_H = 1'b0;
   logic          CpuReq_H = 1'b0;
   logic          CpuDramSelect_H = 1'b0;
   logic [AW-1:0] CpuAddress = '0;
   logic          CpuDtack_L;
   logic          DmaReq_H = 1'b0;
   logic [AW-1:0] DmaAddress = '0;
   logic          DmaAck_H;
   logic          RefreshReq_H = 1'b0;
   logic          RefreshGrant_H;
   logic          DramStart_H;
   logic          DramRefresh_H;
   logic [AW-1:0] DramAddress;
   logic          DramDone_H = 1'b0;
   logic          BusError_L;
   logic [1:0]    Owner;

   int testCount = 0;
   int failCount = 0;
   int lastServed = O_DMA;
   logic [AW-1:0] curAddr = '0;

   dram_access_arbiter #(
      .ADDR_WIDTH     (AW),
      .TIMEOUT_CYCLES (TO_CYCLES),
      .TIMEOUT_WIDTH  (8)
   ) dut (
      .Clock           (Clock),
      .Reset_H         (Reset_H),
      .CpuReq_H        (CpuReq_H),
      .CpuDramSelect_H (CpuDramSelect_H),
      .CpuAddress      (CpuAddress),
      .CpuDtack_L      (CpuDtack_L),
      .DmaReq_H        (DmaReq_H),
      .DmaAddress      (DmaAddress),
      .DmaAck_H        (DmaAck_H),
      .RefreshReq_H    (RefreshReq_H),
      .RefreshGrant_H  (RefreshGrant_H),
      .DramStart_H     (DramStart_H),
      .DramRefresh_H   (DramRefresh_H),
      .DramAddress     (DramAddress),
      .DramDone_H      (DramDone_H),
      .BusError_L      (BusError_L),
      .Owner           (Owner)
   );

   always #5 Clock = ~Clock;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      testCount++;
      if (got !== exp) begin
         failCount++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkEq({tag, ".owner"}, 32'(Owner), O_NONE);
      checkEq({tag, ".start"}, 32'(DramStart_H), 0);
      checkEq({tag, ".refresh"}, 32'(DramRefresh_H), 0);
      checkEq({tag, ".rgrant"}, 32'(RefreshGrant_H), 0);
      checkEq({tag, ".dmaAck"}, 32'(DmaAck_H), 0);
      checkEq({tag, ".dtack"}, 32'(CpuDtack_L), 1);
      checkEq({tag, ".berr"}, 32'(BusError_L), 1);
      checkEq({tag, ".addr"}, DramAddress, curAddr);
   endtask

   task automatic dropAll();
      CpuReq_H = 1'b0;
      CpuDramSelect_H = 1'b0;
      DmaReq_H = 1'b0;
      RefreshReq_H = 1'b0;
      DramDone_H = 1'b0;
   endtask

   // One complete access (or a non-granting attempt) checked against the rules.
   task automatic runRound(input bit cpu, input bit sel, input bit dma, input bit rfr,
                           input logic [AW-1:0] cpuAddr, input logic [AW-1:0] dmaAddr,
                           input int doneLat, input bit dropMid, input int hold,
                           input bit levelDone);
      int win;
      bit timedOut;
      int endLat;
      logic [AW-1:0] expAddr;
      logic expDtack;
      logic expBerr;
      CpuReq_H = cpu;
      CpuDramSelect_H = sel;
      DmaReq_H = dma;
      RefreshReq_H = rfr;
      CpuAddress = cpuAddr;
      DmaAddress = dmaAddr;
      if (rfr) win = O_REF;
      else if (cpu && sel && dma) win = (lastServed == O_CPU) ? O_DMA : O_CPU;
      else if (cpu && sel) win = O_CPU;
      else if (dma) win = O_DMA;
      else win = O_NONE;
      tick();
      if (win == O_NONE) begin
         for (int i = 0; i < 3; i++) begin
            checkIdleOutputs("noGrant");
            tick();
         end
         dropAll();
         return;
      end
      if (win == O_CPU || win == O_DMA) lastServed = win;
      expAddr = (win == O_CPU) ? cpuAddr : (win == O_DMA) ? dmaAddr : '0;
      curAddr = expAddr;
      checkEq("grant.owner", 32'(Owner), win);
      checkEq("grant.start", 32'(DramStart_H), 1);
      checkEq("grant.refresh", 32'(DramRefresh_H), 32'(win == O_REF));
      checkEq("grant.addr", DramAddress, expAddr);
      checkEq("grant.rgrant", 32'(RefreshGrant_H), 32'(win == O_REF));
      // Losers go away; address inputs wander; a stray done must be ignored.
      if (win != O_CPU) begin CpuReq_H = 1'b0; CpuDramSelect_H = 1'b0; end
      if (win != O_DMA) DmaReq_H = 1'b0;
      if (win != O_REF) RefreshReq_H = 1'b0;
      CpuAddress = $urandom;
      DmaAddress = $urandom;
      DramDone_H = 1'($urandom_range(0, 1));
      timedOut = !(doneLat >= 1 && doneLat <= TO_CYCLES);
      endLat = timedOut ? TO_CYCLES : doneLat;
      for (int c = 1; c <= endLat; c++) begin
         tick();
         DramDone_H = (c == doneLat);
         if (dropMid && c == 1) begin
            CpuReq_H = 1'b0;
            DmaReq_H = 1'b0;
            RefreshReq_H = 1'b0;
         end
         checkEq("wait.start", 32'(DramStart_H), 0);
         checkEq("wait.owner", 32'(Owner), win);
         checkEq("wait.addr", DramAddress, expAddr);
         checkEq("wait.dtack", 32'(CpuDtack_L), 1);
         checkEq("wait.dmaAck", 32'(DmaAck_H), 0);
         checkEq("wait.berr", 32'(BusError_L), 1);
         checkEq("wait.rgrant", 32'(RefreshGrant_H), 32'(win == O_REF));
      end
      tick();
      DramDone_H = levelDone && !timedOut;
      expDtack = !(win == O_CPU && !timedOut);
      expBerr  = !(timedOut && (win == O_CPU || win == O_DMA));
      checkEq("end.owner", 32'(Owner), win);
      checkEq("end.dtack", 32'(CpuDtack_L), 32'(expDtack));
      checkEq("end.dmaAck", 32'(DmaAck_H), 32'(win == O_DMA && !timedOut));
      checkEq("end.berr", 32'(BusError_L), 32'(expBerr));
      if (!timedOut) begin
         tick();
         checkEq("rel.dmaAck", 32'(DmaAck_H), 0);
         checkEq("rel.dtack", 32'(CpuDtack_L), 32'(expDtack));
         checkEq("rel.owner", 32'(Owner), win);
      end
      if (!dropMid) begin
         for (int h = 0; h < hold; h++) begin
            DramDone_H = 1'($urandom_range(0, 1));
            tick();
            checkEq("hold.owner", 32'(Owner), win);
            checkEq("hold.dtack", 32'(CpuDtack_L), 32'(expDtack));
            checkEq("hold.berr", 32'(BusError_L), 32'(expBerr));
            checkEq("hold.addr", DramAddress, expAddr);
         end
      end
      dropAll();
      tick();
      checkIdleOutputs("release");
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "bench time limit");
   end

   initial begin
      bit cpu, sel, dma, rfr, dropMid, levelDone;
      int lat, hold;
      logic [AW-1:0] ca, da;

      #1 Reset_H = 1'b1;
      #1 checkIdleOutputs("reset");
      repeat (2) @(posedge Clock);
      #3 Reset_H = 1'b0;
      tick();
      checkIdleOutputs("postReset");

      runRound(1, 1, 0, 0, 32'h0800_0010, 32'h0, 3, 0, 2, 0);
      for (int i = 0; i < 4; i++)
         runRound(1, 1, 1, 0, 32'h0800_0100 + 32'(i), 32'h1234_0000 + 32'(i), 2, 0, 1, 0);
      runRound(1, 1, 1, 1, 32'h0900_0000, 32'h2000_0000, 4, 0, 1, 1);
      runRound(1, 1, 1, 0, 32'h0900_0004, 32'h2000_0004, 1, 0, 0, 0);
      runRound(1, 0, 0, 0, 32'h0040_0000, 32'h0, 3, 0, 0, 0);
      runRound(1, 1, 0, 0, 32'h0800_0200, 32'h0, 0, 0, 2, 0);
      runRound(0, 0, 1, 0, 32'h0, 32'h3000_0000, TO_CYCLES, 0, 0, 0);
      runRound(0, 0, 1, 0, 32'h0, 32'h3000_0040, 1, 1, 0, 0);

      // Asynchronous reset in the middle of WAIT, off the clock edge.
      CpuReq_H = 1'b1; CpuDramSelect_H = 1'b1; CpuAddress = 32'h0A00_0000;
      tick(); tick(); tick();
      #3 Reset_H = 1'b1;
      dropAll();
      lastServed = O_DMA;
      curAddr = '0;
      #1 checkIdleOutputs("midReset");
      #2 Reset_H = 1'b0;
      tick();
      runRound(1, 1, 1, 0, 32'h0A00_0010, 32'h4000_0000, 2, 0, 0, 0);

      for (int r = 0; r < 200; r++) begin
         cpu = 1'($urandom_range(0, 1));
         sel = ($urandom_range(0, 4) != 0);
         dma = 1'($urandom_range(0, 1));
         rfr = ($urandom_range(0, 3) == 0);
         ca  = sel ? (32'h0800_0000 | ($urandom & 32'h03FF_FFFF)) : ($urandom & 32'h07FF_FFFF);
         da  = $urandom;
         lat = $urandom_range(0, 11);
         dropMid   = ($urandom_range(0, 4) == 0);
         hold      = $urandom_range(0, 3);
         levelDone = 1'($urandom_range(0, 1));
         runRound(cpu, sel, dma, rfr, ca, da, lat, dropMid, hold, levelDone);
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule

// File: doc/dram_access_arbiter.md
Name: dram_access_arbiter

Overview:
Shares the single DRAM controller port among three requesters: the 68k CPU (DRAM window 0800_0000–0BFF_FFFF), the DMA engine, and the periodic refresh timer. It sequences every access as grant -> start pulse -> wait for done -> acknowledge -> release. A watchdog aborts hung accesses. The block sits between the address decoder/DMA block and the DRAM controller.

Parameters:
ADDR_WIDTH, 32, width of latched/forwarded address
TIMEOUT_CYCLES, 255, max cycles in WAIT before abort (1..2^TIMEOUT_WIDTH-1)
TIMEOUT_WIDTH, 8, watchdog counter width

Ports:
Clock  in  1  system clock, rising edge
Reset_H  in  1  asynchronous, active-high reset
CpuReq_H  in  1  CPU bus cycle active (AS qualified)
CpuDramSelect_H  in  1  decoder DramSelect_H; gates CpuReq_H
CpuAddress  in  ADDR_WIDTH  CPU address
CpuDtack_L  out  1  data acknowledge to CPU
DmaReq_H  in  1  DMA access request
DmaAddress  in  ADDR_WIDTH  DMA address
DmaAck_H  out  1  DMA access complete
RefreshReq_H  in  1  refresh due (level, held until granted)
RefreshGrant_H  out  1  refresh cycle owns DRAM
DramStart_H  out  1  one-cycle start pulse to DRAM controller
DramRefresh_H  out  1  qualifies DramStart_H as refresh
DramAddress  out  ADDR_WIDTH  latched address of current owner
DramDone_H  in  1  DRAM controller completion (one cycle or level)
BusError_L  out  1  timeout abort to current owner
Owner  out  2  00 none, 01 CPU, 10 DMA, 11 refresh

Behaviour:
- Reset (async, any state): state IDLE; Owner=00; DramStart_H=0; DramRefresh_H=0; RefreshGrant_H=0; DmaAck_H=0; CpuDtack_L=1; BusError_L=1; DramAddress=0; watchdog=0; LastServed=DMA.
- Effective CPU request = CpuReq_H & CpuDramSelect_H.
- States: IDLE, START, WAIT, ACK, RELEASE.
- IDLE: priority refresh > round-robin(CPU, DMA). If only one of CPU/DMA requests, it wins. If both request, the one not equal to LastServed wins. On win: latch Owner, latch DramAddress (0 for refresh), update LastServed (CPU/DMA only), go to START. Refresh is never preempting.
- START: DramStart_H=1 for exactly one cycle (DramRefresh_H=1 if Owner=11); clear watchdog; go to WAIT. Latency from request sampled in IDLE to start pulse: 1 cycle.
- WAIT: watchdog increments each cycle. DramDone_H=1 -> ACK. If the watchdog reaches TIMEOUT_CYCLES without done -> assert BusError_L=0 (CPU/DMA owners) and go to RELEASE. DramDone_H on the same cycle as expiry: done wins.
- ACK: CPU owner: CpuDtack_L=0, held through RELEASE until CpuReq_H drops. DMA owner: DmaAck_H=1 for exactly one cycle. Refresh owner: nothing. Go to RELEASE.
- RELEASE: wait until owner's request deasserts (refresh: RefreshReq_H=0), then clear Owner, CpuDtack_L=1, BusError_L=1, RefreshGrant_H=0, and go to IDLE. Minimum one IDLE cycle between accesses.
- RefreshGrant_H=1 from START through RELEASE while Owner=11.
- DramAddress is stable from START until return to IDLE; no mid-access change when requester inputs change.
- A requester dropping its request mid-WAIT does not abort the access; it completes and its ACK is issued (DMA pulse still generated).
- Watchdog saturates; no wrap.
- DramDone_H outside WAIT is ignored.

Decomposition:
- Shared package: owner encodings (OWNER_NONE/CPU/DMA/REFRESH), state encodings, DRAM window constants 32'h0800_0000/32'h0BFF_FFFF.
- One natural sub-module: access_watchdog (clear, enable, TIMEOUT_CYCLES compare, expired flag).

Test Plan:
- CPU read at 0800_0010, DramDone_H 3 cycles after start -> DramStart_H pulse 1 cycle after request, DramAddress=0800_0010, CpuDtack_L low until CpuReq_H drops, Owner=01 then 00.
- CPU and DMA request same cycle after reset -> CPU granted first; on the next tie DMA is granted (alternation over 4 accesses: CPU, DMA, CPU, DMA).
- RefreshReq_H with CPU and DMA pending in IDLE -> Owner=11, DramRefresh_H=1 with start; CPU served after refresh release.
- CpuReq_H with CpuDramSelect_H=0 (address 0040_0000) -> no grant, outputs stay at reset values.
- DramDone_H never asserted, TIMEOUT_CYCLES=8 -> BusError_L low exactly 8 cycles after START exits, no CpuDtack_L; recovers to IDLE after CpuReq_H drops.
- Reset_H pulsed mid-WAIT (asynchronous, not aligned to Clock) -> all outputs return to reset values immediately; next tie grants CPU.
